// File: rtl/id_stage_hz_pkg.sv
// mips_pkg: shared definitions for the id_stage_hz decode slice.
//   - opcode values recognised by the decoder
//   - bit positions inside the wb / mem / execute control bundles
//   - bundle widths and the packed control-bundle type
//   - decode helper mapping an opcode to its control bundle
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam int WB_W  = 2;
  localparam int MEM_W = 3;
  localparam int EX_W  = 4;

  localparam int WB_REGWRITE  = 1;
  localparam int WB_MEMTOREG  = 0;
  localparam int MEM_BRANCH   = 2;
  localparam int MEM_MEMREAD  = 1;
  localparam int MEM_MEMWRITE = 0;
  localparam int EX_REGDST    = 3;
  localparam int EX_ALUOP_HI  = 2;
  localparam int EX_ALUOP_LO  = 1;
  localparam int EX_ALUSRC    = 0;

  typedef struct packed {
    logic [WB_W-1:0]  wb;
    logic [MEM_W-1:0] mem;
    logic [EX_W-1:0]  ex;
    logic             legal;
  } ctrl_t;

  function automatic ctrl_t decode_op(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: c = '{wb: 2'b10, mem: 3'b000, ex: 4'b1100, legal: 1'b1};
      OP_LW:    c = '{wb: 2'b11, mem: 3'b010, ex: 4'b0001, legal: 1'b1};
      OP_SW:    c = '{wb: 2'b00, mem: 3'b001, ex: 4'b0001, legal: 1'b1};
      OP_BEQ:   c = '{wb: 2'b00, mem: 3'b100, ex: 4'b0010, legal: 1'b1};
      OP_ADDI:  c = '{wb: 2'b10, mem: 3'b000, ex: 4'b0001, legal: 1'b1};
      OP_ANDI,
      OP_ORI:   c = '{wb: 2'b10, mem: 3'b000, ex: 4'b0111, legal: 1'b1};
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_hz_regfile_bp.sv
// regfile_bp: NREG x DATA_W register file with two read ports and one
// write port. Register 0 and addresses >= NREG read as zero and ignore
// writes. A write to a readable register is forwarded to the read ports in
// the same cycle (write-through bypass).
// Ports: clk, rst (sync, active-high, clears all registers),
//        rd_addr1/rd_addr2 -> rd_data1/rd_data2, wr_en/wr_addr/wr_data.
module regfile_bp
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rd_addr1,
  input  logic [4:0]        rd_addr2,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  localparam logic [5:0] NREG_L = 6'(NREG);

  logic [DATA_W-1:0] regs [NREG];

  function automatic logic live_addr(input logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < NREG_L);
  endfunction

  logic wr_ok;
  assign wr_ok = wr_en && live_addr(wr_addr);

  always_comb begin
    rd_data1 = '0;
    if (live_addr(rd_addr1))
      rd_data1 = (wr_ok && wr_addr == rd_addr1) ? wr_data : regs[rd_addr1[REG_AW-1:0]];
  end

  always_comb begin
    rd_data2 = '0;
    if (live_addr(rd_addr2))
      rd_data2 = (wr_ok && wr_addr == rd_addr2) ? wr_data : regs[rd_addr2[REG_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr[REG_AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/id_stage_hz.sv
// id_stage_hz: MIPS instruction-decode stage with load-use hazard stall,
// branch-flush bubble insertion and WB-to-ID write-through bypass.
// Inputs : clk, rst, IF/ID latch (if_id_valid/instr/npc), WB write port
//          (wb_reg_write, wb_write_reg_location, mem_wb_write_data), ex_flush.
// Outputs: pc_write / if_id_write stall handshake to fetch, ID/EX register
//          (valid, wb/mem/execute controls, npc, rs/rt data, extended
//          immediate, rs/rt/rd numbers) and a saturating stall counter.
module id_stage_hz
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_id_valid,
  input  logic [31:0]       if_id_instr,
  input  logic [DATA_W-1:0] if_id_npc,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_write_reg_location,
  input  logic [DATA_W-1:0] mem_wb_write_data,
  input  logic              ex_flush,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_valid,
  output logic [1:0]        id_ex_wb,
  output logic [2:0]        id_ex_mem,
  output logic [3:0]        id_ex_execute,
  output logic [DATA_W-1:0] id_ex_npc,
  output logic [DATA_W-1:0] id_ex_readdat1,
  output logic [DATA_W-1:0] id_ex_readdat2,
  output logic [DATA_W-1:0] id_ex_sign_ext,
  output logic [4:0]        id_ex_instr_bits_25_21,
  output logic [4:0]        id_ex_instr_bits_20_16,
  output logic [4:0]        id_ex_instr_bits_15_11,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int REG_AW = $clog2(NREG);

  // Decode (ID) stage: fields of the instruction held in IF/ID
  logic [5:0]        op_p0;
  logic [4:0]        rs_p0, rt_p0, rd_p0;
  logic [15:0]       imm_p0;
  ctrl_t             ctrl_p0;
  logic [DATA_W-1:0] imm_ext_p0;
  logic [DATA_W-1:0] rdat1_p0, rdat2_p0;
  logic              uses_rt_p0;
  logic              stall;
  logic              bubble_p0;

  assign op_p0   = if_id_instr[31:26];
  assign rs_p0   = if_id_instr[25:21];
  assign rt_p0   = if_id_instr[20:16];
  assign rd_p0   = if_id_instr[15:11];
  assign imm_p0  = if_id_instr[15:0];
  assign ctrl_p0 = decode_op(op_p0);

  // Logical immediates are zero-extended; everything else sign-extends.
  assign imm_ext_p0 = (op_p0 == OP_ANDI || op_p0 == OP_ORI)
                    ? {{(DATA_W-16){1'b0}}, imm_p0}
                    : {{(DATA_W-16){imm_p0[15]}}, imm_p0};

  // Only R-type, sw and beq actually read rt as a source operand.
  assign uses_rt_p0 = (op_p0 == OP_RTYPE) || (op_p0 == OP_SW) || (op_p0 == OP_BEQ);

  regfile_bp #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rd_addr1 (rs_p0),
    .rd_addr2 (rt_p0),
    .wr_en    (wb_reg_write),
    .wr_addr  (wb_write_reg_location),
    .wr_data  (mem_wb_write_data),
    .rd_data1 (rdat1_p0),
    .rd_data2 (rdat2_p0)
  );

  // A load in EX whose destination feeds the instruction in ID must wait one
  // cycle; a concurrent flush discards that instruction, so no stall then.
  assign stall = id_ex_valid && id_ex_mem[MEM_MEMREAD]
              && (id_ex_instr_bits_20_16 != 5'd0) && if_id_valid
              && ((id_ex_instr_bits_20_16 == rs_p0)
                  || (id_ex_instr_bits_20_16 == rt_p0 && uses_rt_p0))
              && !ex_flush;

  assign pc_write    = !stall;
  assign if_id_write = !stall;

  assign bubble_p0 = ex_flush || stall || !(if_id_valid && ctrl_p0.legal);

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_valid            <= 1'b0;
      id_ex_wb               <= '0;
      id_ex_mem              <= '0;
      id_ex_execute          <= '0;
      id_ex_npc              <= '0;
      id_ex_readdat1         <= '0;
      id_ex_readdat2         <= '0;
      id_ex_sign_ext         <= '0;
      id_ex_instr_bits_25_21 <= '0;
      id_ex_instr_bits_20_16 <= '0;
      id_ex_instr_bits_15_11 <= '0;
      stall_count            <= '0;
    end else begin
      if (bubble_p0) begin
        id_ex_valid            <= 1'b0;
        id_ex_wb               <= '0;
        id_ex_mem              <= '0;
        id_ex_execute          <= '0;
        id_ex_npc              <= '0;
        id_ex_readdat1         <= '0;
        id_ex_readdat2         <= '0;
        id_ex_sign_ext         <= '0;
        id_ex_instr_bits_25_21 <= '0;
        id_ex_instr_bits_20_16 <= '0;
        id_ex_instr_bits_15_11 <= '0;
      end else begin
        id_ex_valid            <= 1'b1;
        id_ex_wb               <= ctrl_p0.wb;
        id_ex_mem              <= ctrl_p0.mem;
        id_ex_execute          <= ctrl_p0.ex;
        id_ex_npc              <= if_id_npc;
        id_ex_readdat1         <= rdat1_p0;
        id_ex_readdat2         <= rdat2_p0;
        id_ex_sign_ext         <= imm_ext_p0;
        id_ex_instr_bits_25_21 <= rs_p0;
        id_ex_instr_bits_20_16 <= rt_p0;
        id_ex_instr_bits_15_11 <= rd_p0;
      end
      if (stall && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_stage_hz.sv
module tb_id_stage_hz;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_id_valid;
  logic [31:0]       if_id_instr;
  logic [DATA_W-1:0] if_id_npc;
  logic              wb_reg_write;
  logic [4:0]        wb_write_reg_location;
  logic [DATA_W-1:0] mem_wb_write_data;
  logic              ex_flush;
  logic              pc_write, if_id_write, id_ex_valid;
  logic [1:0]        id_ex_wb;
  logic [2:0]        id_ex_mem;
  logic [3:0]        id_ex_execute;
  logic [DATA_W-1:0] id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext;
  logic [4:0]        id_ex_instr_bits_25_21, id_ex_instr_bits_20_16, id_ex_instr_bits_15_11;
  logic [CNT_W-1:0]  stall_count;

  int n_chk  = 0;
  int n_fail = 0;

  id_stage_hz #(.DATA_W(DATA_W), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .if_id_valid            (if_id_valid),
    .if_id_instr            (if_id_instr),
    .if_id_npc              (if_id_npc),
    .wb_reg_write           (wb_reg_write),
    .wb_write_reg_location  (wb_write_reg_location),
    .mem_wb_write_data      (mem_wb_write_data),
    .ex_flush               (ex_flush),
    .pc_write               (pc_write),
    .if_id_write            (if_id_write),
    .id_ex_valid            (id_ex_valid),
    .id_ex_wb               (id_ex_wb),
    .id_ex_mem              (id_ex_mem),
    .id_ex_execute          (id_ex_execute),
    .id_ex_npc              (id_ex_npc),
    .id_ex_readdat1         (id_ex_readdat1),
    .id_ex_readdat2         (id_ex_readdat2),
    .id_ex_sign_ext         (id_ex_sign_ext),
    .id_ex_instr_bits_25_21 (id_ex_instr_bits_25_21),
    .id_ex_instr_bits_20_16 (id_ex_instr_bits_20_16),
    .id_ex_instr_bits_15_11 (id_ex_instr_bits_15_11),
    .stall_count            (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic issue(input logic [31:0] ins, input logic [31:0] npc);
    if_id_valid = 1'b1;
    if_id_instr = ins;
    if_id_npc   = npc;
  endtask

  task automatic wb(input logic en, input logic [4:0] loc, input logic [31:0] dat);
    wb_reg_write          = en;
    wb_write_reg_location = loc;
    mem_wb_write_data     = dat;
  endtask

  initial begin
    rst = 1'b1;
    if_id_valid = 1'b0;
    if_id_instr = '0;
    if_id_npc = '0;
    ex_flush = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;

    // Reset and idle
    check("rst_valid", id_ex_valid, 1'b0);
    check("rst_wb", id_ex_wb, 2'b00);
    check("rst_mem", id_ex_mem, 3'b000);
    check("rst_ex", id_ex_execute, 4'b0000);
    check("rst_rd1", id_ex_readdat1, 32'd0);
    check("rst_npc", id_ex_npc, 32'd0);
    check("rst_pcw", pc_write, 1'b1);
    check("rst_ifidw", if_id_write, 1'b1);
    check("rst_cnt", stall_count, 16'd0);
    step();
    check("idle_valid", id_ex_valid, 1'b0);

    // Bypass: WB writes r5 while add r1,r5,r6 decodes
    issue(r_ins(5'd5, 5'd6, 5'd1), 32'h104);
    wb(1'b1, 5'd5, 32'h1234);
    step();
    check("byp_rd1", id_ex_readdat1, 32'h1234);
    check("byp_rd2", id_ex_readdat2, 32'h0);
    check("byp_valid", id_ex_valid, 1'b1);
    check("rtype_wb", id_ex_wb, 2'b10);
    check("rtype_mem", id_ex_mem, 3'b000);
    check("rtype_ex", id_ex_execute, 4'b1100);
    check("rtype_rd", id_ex_instr_bits_15_11, 5'd1);
    check("rtype_rs", id_ex_instr_bits_25_21, 5'd5);
    check("rtype_npc", id_ex_npc, 32'h104);

    // r5 stored; write to r0 ignored both via bypass and storage
    issue(r_ins(5'd0, 5'd5, 5'd2), 32'h108);
    wb(1'b1, 5'd0, 32'hDEAD);
    step();
    check("r0_byp", id_ex_readdat1, 32'h0);
    check("r5_stored", id_ex_readdat2, 32'h1234);
    wb(1'b0, 5'd0, 32'h0);
    step();
    check("r0_read", id_ex_readdat1, 32'h0);

    // lw r2,0(r1) then add r3,r2,r4: one stall
    issue(i_ins(6'h23, 5'd1, 5'd2, 16'h0), 32'h200);
    step();
    check("lw_wb", id_ex_wb, 2'b11);
    check("lw_mem", id_ex_mem, 3'b010);
    check("lw_ex", id_ex_execute, 4'b0001);
    issue(r_ins(5'd2, 5'd4, 5'd3), 32'h204);
    #1;
    check("lu_pcw", pc_write, 1'b0);
    check("lu_ifidw", if_id_write, 1'b0);
    step();
    check("lu_bub_valid", id_ex_valid, 1'b0);
    check("lu_bub_wb", id_ex_wb, 2'b00);
    check("lu_bub_mem", id_ex_mem, 3'b000);
    check("lu_cnt", stall_count, 16'd1);
    check("lu_clear_pcw", pc_write, 1'b1);
    step();
    check("lu_issue_valid", id_ex_valid, 1'b1);
    check("lu_issue_rd", id_ex_instr_bits_15_11, 5'd3);
    check("lu_cnt_hold", stall_count, 16'd1);

    // lw r2 then addi r7,r2,1: rs dependency stalls
    issue(i_ins(6'h23, 5'd1, 5'd2, 16'h0), 32'h300);
    step();
    issue(i_ins(6'h08, 5'd2, 5'd7, 16'h1), 32'h304);
    #1;
    check("rs_dep_pcw", pc_write, 1'b0);
    step();
    check("rs_dep_bub", id_ex_valid, 1'b0);
    check("rs_dep_cnt", stall_count, 16'd2);
    step();
    check("addi_valid", id_ex_valid, 1'b1);
    check("addi_imm", id_ex_sign_ext, 32'h1);

    // lw r2 then addi r2,r9,1: rt is a destination, no stall
    issue(i_ins(6'h23, 5'd1, 5'd2, 16'h0), 32'h400);
    step();
    issue(i_ins(6'h08, 5'd9, 5'd2, 16'h1), 32'h404);
    #1;
    check("rt_dst_pcw", pc_write, 1'b1);
    step();
    check("rt_dst_valid", id_ex_valid, 1'b1);
    check("rt_dst_cnt", stall_count, 16'd2);

    // Stall condition with ex_flush: flush wins
    issue(i_ins(6'h23, 5'd1, 5'd2, 16'h0), 32'h500);
    step();
    issue(r_ins(5'd2, 5'd4, 5'd3), 32'h504);
    ex_flush = 1'b1;
    #1;
    check("fl_pcw", pc_write, 1'b1);
    check("fl_ifidw", if_id_write, 1'b1);
    step();
    ex_flush = 1'b0;
    check("fl_valid", id_ex_valid, 1'b0);
    check("fl_wb", id_ex_wb, 2'b00);
    check("fl_cnt", stall_count, 16'd2);

    // Immediate extension
    issue(i_ins(6'h0D, 5'd0, 5'd1, 16'h8000), 32'h600);
    step();
    check("ori_imm", id_ex_sign_ext, 32'h0000_8000);
    check("ori_ex", id_ex_execute, 4'b0111);
    issue(i_ins(6'h08, 5'd0, 5'd1, 16'h8000), 32'h604);
    step();
    check("addi_neg_imm", id_ex_sign_ext, 32'hFFFF_8000);
    check("addi_ex", id_ex_execute, 4'b0001);

    // sw and beq decode
    issue(i_ins(6'h2B, 5'd1, 5'd5, 16'h4), 32'h608);
    step();
    check("sw_mem", id_ex_mem, 3'b001);
    check("sw_wb", id_ex_wb, 2'b00);
    issue(i_ins(6'h04, 5'd1, 5'd5, 16'hFFFE), 32'h60C);
    step();
    check("beq_mem", id_ex_mem, 3'b100);
    check("beq_ex", id_ex_execute, 4'b0010);

    // Illegal opcode becomes a bubble
    issue({6'h3F, 26'h0A5_5A5A}, 32'h610);
    step();
    check("ill_valid", id_ex_valid, 1'b0);
    check("ill_ctrl", {id_ex_wb, id_ex_mem, id_ex_execute}, 9'd0);

    // Load with rt=0 never stalls
    issue(i_ins(6'h23, 5'd1, 5'd0, 16'h0), 32'h700);
    step();
    issue(r_ins(5'd0, 5'd0, 5'd3), 32'h704);
    #1;
    check("lw_r0_pcw", pc_write, 1'b1);
    step();
    check("lw_r0_cnt", stall_count, 16'd2);

    // WB write during a stall is seen after the stall
    issue(i_ins(6'h23, 5'd1, 5'd2, 16'h0), 32'h800);
    step();
    issue(r_ins(5'd2, 5'd4, 5'd3), 32'h804);
    wb(1'b1, 5'd2, 32'h55);
    #1;
    check("wbst_pcw", pc_write, 1'b0);
    step();
    wb(1'b0, 5'd0, 32'h0);
    check("wbst_cnt", stall_count, 16'd3);
    step();
    check("wbst_valid", id_ex_valid, 1'b1);
    check("wbst_rd1", id_ex_readdat1, 32'h55);

    // Reset has priority over a valid instruction
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_valid", id_ex_valid, 1'b0);
    check("rst2_cnt", stall_count, 16'd0);
    if_id_valid = 1'b0;
    issue(r_ins(5'd5, 5'd0, 5'd1), 32'h900);
    step();
    check("rst2_reg_clr", id_ex_readdat1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_hz.md
# id_stage_hz

Parametrised second-generation MIPS instruction-decode stage: control decode, immediate extension, register file and ID/EX pipeline register in one block. It adds three things:
- load-use hazard detection with a stall handshake back to fetch;
- branch-flush bubble insertion;
- WB-to-ID write-through bypass.

It sits between the IF/ID latch and the execute stage. Data width and register count are parameters.

## Interface
Parameters:
- DATA_W, 32, datapath/PC width; legal values ≥ 32
- NREG, 32, implemented registers (2..32); REG_AW = $clog2(NREG)
- CNT_W, 16, stall-counter width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- if_id_valid  in  1  IF/ID holds a real instruction
- if_id_instr  in  32  instruction word
- if_id_npc  in  DATA_W  PC+4 of that instruction
- wb_reg_write  in  1  WB write enable
- wb_write_reg_location  in  5  WB destination register
- mem_wb_write_data  in  DATA_W  WB data
- ex_flush  in  1  branch taken; squash the instruction in ID
- pc_write  out  1  PC may advance
- if_id_write  out  1  IF/ID may load
- id_ex_valid  out  1  ID/EX holds a real instruction
- id_ex_wb  out  2  {RegWrite, MemToReg}
- id_ex_mem  out  3  {Branch, MemRead, MemWrite}
- id_ex_execute  out  4  {RegDst, ALUOp[1:0], ALUSrc}
- id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext  out  DATA_W each  latched PC+4, rs data, rt data, extended immediate
- id_ex_instr_bits_25_21, id_ex_instr_bits_20_16, id_ex_instr_bits_15_11  out  5 each  rs, rt, rd
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
Opcode decode, giving {wb, mem, execute}:
- 0x00 R-type: 2'b10, 3'b000, 4'b1100
- 0x23 lw: 2'b11, 3'b010, 4'b0001
- 0x2B sw: 2'b00, 3'b001, 4'b0001
- 0x04 beq: 2'b00, 3'b100, 4'b0010
- 0x08 addi: 2'b10, 3'b000, 4'b0001
- 0x0C andi and 0x0D ori: 2'b10, 3'b000, 4'b0111
- Any other opcode: all-zero control, treated as a bubble (id_ex_valid=0).

Immediate:
- andi and ori zero-extend instr[15:0] to DATA_W.
- All other opcodes sign-extend it.

Register file:
- NREG×DATA_W entries.
- Register 0 always reads 0, and writes to it are ignored.
- Addresses ≥ NREG read 0, and writes to them are ignored.
- Write bypass: when wb_reg_write=1 and wb_write_reg_location equals a nonzero, in-range rs or rt, the read returns mem_wb_write_data in the same cycle.

Load-use hazard:
- `stall` = id_ex_valid & id_ex_mem[1] & (id_ex_rt ≠ 0) & if_id_valid & (id_ex_rt == rs | (id_ex_rt == rt & opcode ∈ {R-type, sw, beq})) & ~ex_flush.
- While `stall`: pc_write=0, if_id_write=0, and ID/EX loads a bubble.

Flush:
- ex_flush=1 makes ID/EX load a bubble regardless of `stall`.
- pc_write=1 and if_id_write=1 during flush, so fetch redirects.

Bubble definition:
- valid, wb, mem and execute are all zero.
- Datapath fields are don't-care, but are loaded as zero.

Normal load: ID/EX captures the decoded instruction; valid = if_id_valid & legal opcode.

stall_count increments on every `stall` cycle and saturates at 2^CNT_W−1.

## Timing
- Reset (rst=1 at a clock edge): every ID/EX output is 0, every register is 0, and stall_count is 0. pc_write=if_id_write=1 in the cycle after reset. rst has priority over every other input.
- Decode→ID/EX latency is 1 cycle.
- pc_write and if_id_write are combinational from the current ID/EX contents, IF/ID and ex_flush.
- A WB write lands at the clock edge and is also visible through the bypass in the same cycle.
- A lw followed immediately by a dependent instruction gives exactly one stall cycle. The next cycle, the producer has moved on, so the hazard clears.
- Simultaneous stall condition and ex_flush: the flush wins, no stall is counted, and a bubble is inserted.
- A WB write during a stall still updates the register file. The instruction held in IF/ID re-reads after the stall, so it sees the new value.
- A load whose rt=0 never stalls.

## Structure
- Package `mips_pkg`:
  - opcode localparams;
  - control-field bit positions (WB_REGWRITE, MEM_MEMREAD, …);
  - widths of the wb/mem/ex bundles;
  - the packed typedef for the control bundle.
- One sub-module, `regfile_bp`: parametrised register file with zero register and write-through bypass.
- Hazard logic, decode, immediate extension and the ID/EX register stay inline.

## Test plan
- Reset, then idle: all outputs 0, pc_write=1, stall_count=0.
- WB writes r5=0x1234 while `add r1,r5,r6` decodes → id_ex_readdat1=0x1234 the next cycle (bypass). A WB write to r0 → a later read of r0 returns 0.
- `lw r2,0(r1)` then `add r3,r2,r4` → one cycle with pc_write=0, if_id_write=0 and an ID/EX bubble; stall_count=1; the add issues the next cycle.
- `lw r2` then `addi r7,r2,1` stalls (rs match). `lw r2` then `addi r2,r9,1` does not stall (rt is a destination).
- Stall condition with ex_flush=1 in the same cycle → bubble, pc_write=1, stall_count unchanged.
- `ori r1,r0,0x8000` → id_ex_sign_ext=0x00008000; `addi` with 0x8000 → 0xFFFF8000. Opcode 0x3F → id_ex_valid=0 with all-zero control.
